// File: rtl/pll_reset_seq.sv
// PLL reset sequencer.
// Synchronises the raw PLL lock flag and waits until it has been stable for
// LOCK_STABLE_CYCLES. It then releases the active-low domain resets one at a
// time, lowest index first, STAGE_GAP cycles apart. Loss of lock or a soft
// reset re-asserts every domain reset on the next edge.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_LOCK | all resets held; waiting for locked_s=1 with force_rst=0
// STABILIZE | counting consecutive locked cycles before the first release
// RELEASE   | releasing rst_out_n[idx] every STAGE_GAP cycles
// RUN       | all resets released, ready=1
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int STAGE_GAP          = 16,
  parameter int NUM_RESETS         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked_in,
  input  logic                  force_rst,
  input  logic                  clear_count,
  output logic [NUM_RESETS-1:0] rst_out_n,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  // One counter serves both the stabilisation and the gap timing, so it is
  // sized for the longer of the two terminal counts.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

  localparam logic [CNT_W-1:0] STAB_TC  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESETS - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [NUM_RESETS-1:0]   rst_out_n_nxt;
  logic                    ready_nxt;
  logic [7:0]              loss_cnt_nxt;
  logic                    sync_q1, locked_s;
  logic                    abort;
  logic                    loss_inc;

  // Two-flop synchroniser; the only logic that looks at locked_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked_in;
      locked_s <= sync_q1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      idx             <= '0;
      rst_out_n       <= '0;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      idx             <= idx_nxt;
      rst_out_n       <= rst_out_n_nxt;
      ready           <= ready_nxt;
      lock_loss_count <= loss_cnt_nxt;
    end
  end

  // Next-state, release scheduling and abort override.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    rst_out_n_nxt = rst_out_n;
    ready_nxt     = ready;

    abort = (state != WAIT_LOCK) && (!locked_s || force_rst);

    case (state)
      WAIT_LOCK: begin
        rst_out_n_nxt = '0;
        ready_nxt     = 1'b0;
        cnt_nxt       = '0;
        idx_nxt       = '0;
        if (locked_s && !force_rst) begin
          state_nxt = STABILIZE;
        end
      end

      STABILIZE: begin
        if (cnt == STAB_TC) begin
          cnt_nxt          = '0;
          rst_out_n_nxt[0] = 1'b1;
          if (NUM_RESETS == 1) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE;
            idx_nxt   = IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (cnt == GAP_TC) begin
          cnt_nxt = '0;
          for (int i = 0; i < NUM_RESETS; i++) begin
            if (idx == IDX_W'(i)) begin
              rst_out_n_nxt[i] = 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RUN: begin
        rst_out_n_nxt = '1;
        ready_nxt     = 1'b1;
      end

      default: begin
        state_nxt     = WAIT_LOCK;
        rst_out_n_nxt = '0;
        ready_nxt     = 1'b0;
        cnt_nxt       = '0;
        idx_nxt       = '0;
      end
    endcase

    // Abort wins over any release that would have happened on this edge.
    if (abort) begin
      state_nxt     = WAIT_LOCK;
      rst_out_n_nxt = '0;
      ready_nxt     = 1'b0;
      cnt_nxt       = '0;
      idx_nxt       = '0;
    end
  end

  // Lock-loss counter: clear first, then a saturating increment on a real
  // lock loss out of RUN. A soft-reset abort with lock still present does
  // not count.
  always_comb begin
    loss_inc     = (state == RUN) && !locked_s;
    loss_cnt_nxt = clear_count ? 8'd0 : lock_loss_count;
    if (loss_inc && (loss_cnt_nxt != 8'hFF)) begin
      loss_cnt_nxt = loss_cnt_nxt + 8'd1;
    end
  end

endmodule
